// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter: default
//   widths, FSM state encodings (3-bit), grant codes and the state->grant map.
//   No ports; imported by the arbiter top level.
package reg_wb_arbiter_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 3;
  localparam int WB_NREGS  = 8;

  // BOTH_* states record which of the two held slots is older.
  typedef enum logic [2:0] {
    ST_EMPTY        = 3'd0,
    ST_ALU_ONLY     = 3'd1,
    ST_MEM_ONLY     = 3'd2,
    ST_BOTH_ALU_OLD = 3'd3,
    ST_BOTH_MEM_OLD = 3'd4
  } wb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } wb_grant_e;

  // The oldest valid slot always owns the write port.
  function automatic wb_grant_e state_grant(input wb_state_e s);
    case (s)
      ST_ALU_ONLY, ST_BOTH_ALU_OLD: state_grant = GNT_ALU;
      ST_MEM_ONLY, ST_BOTH_MEM_OLD: state_grant = GNT_MEM;
      default:                      state_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if
//   Bundles the two writeback source handshakes (ALU and load path), the
//   reg_file write port and the per-register pending mask.
//   slave  : arbiter side (takes requests, drives ready/write port/pending)
//   master : source/reg_file side
interface reg_wb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) ();

  logic              alu_req;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [NREGS-1:0]  pending;

  modport slave (
    input  alu_req, alu_reg, alu_data,
    output alu_ready,
    input  mem_req, mem_reg, mem_data,
    output mem_ready,
    output write_reg, write_data, write_enable, pending
  );

  modport master (
    output alu_req, alu_reg, alu_data,
    input  alu_ready,
    output mem_req, mem_reg, mem_data,
    input  mem_ready,
    input  write_reg, write_data, write_enable, pending
  );

endinterface

// File: rtl/reg_wb_arbiter_wb_hold_slot.sv
// wb_hold_slot
//   One-entry holding register for a pending register-file write.
//   Ports: clk_i, rst_i (async, active-high), load_i (capture reg_i/data_i,
//   wins over clear), clear_i (drop the entry), valid_o/reg_o/data_o (held entry).
module wb_hold_slot #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] reg_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] reg_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] reg_q;
  logic [DATA_W-1:0] data_q;

  // Load beats clear so a drained slot can refill on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      reg_q   <= reg_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign reg_o   = reg_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Shares the single reg_file write port between the ALU result path and the
//   load path. Each source has a one-entry hold slot; held writes drain
//   oldest-first, one per clock. Also exports a per-register pending mask.
//   Ports: clk_i, rst_i (async, active-high), wb (reg_wb_arbiter_if.slave):
//   alu_*/mem_* request handshakes, write_reg/write_data/write_enable to
//   reg_file, pending[NREGS].
//
//   state           | meaning
//   ST_EMPTY        | no slot holds a write
//   ST_ALU_ONLY     | only the ALU slot is valid, it is granted
//   ST_MEM_ONLY     | only the MEM slot is valid, it is granted
//   ST_BOTH_ALU_OLD | both valid, ALU entry older and granted
//   ST_BOTH_MEM_OLD | both valid, MEM entry older and granted
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int NREGS  = WB_NREGS
) (
  input logic              clk_i,
  input logic              rst_i,
  reg_wb_arbiter_if.slave  wb
);

  wb_state_e state_q, state_d;
  wb_grant_e grant;

  logic              alu_v, mem_v;
  logic [ADDR_W-1:0] alu_reg_q, mem_reg_q;
  logic [DATA_W-1:0] alu_data_q, mem_data_q;

  logic alu_drain, mem_drain;
  logic alu_take, mem_take;
  logic alu_keep, mem_keep;
  logic alu_v_d, mem_v_d;
  logic [ADDR_W-1:0] alu_reg_d, mem_reg_d;
  logic [NREGS-1:0]  pending_d, pending_q;

  assign grant     = state_grant(state_q);
  assign alu_drain = (grant == GNT_ALU);
  assign mem_drain = (grant == GNT_MEM);

  // A granted slot empties at this edge, so it can take a new entry too.
  assign wb.alu_ready = !alu_v || alu_drain;
  assign wb.mem_ready = !mem_v || mem_drain;

  assign alu_take = wb.alu_req && wb.alu_ready;
  assign mem_take = wb.mem_req && wb.mem_ready;
  assign alu_keep = alu_v && !alu_drain;
  assign mem_keep = mem_v && !mem_drain;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (alu_take),
    .clear_i (alu_drain),
    .reg_i   (wb.alu_reg),
    .data_i  (wb.alu_data),
    .valid_o (alu_v),
    .reg_o   (alu_reg_q),
    .data_o  (alu_data_q)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (mem_take),
    .clear_i (mem_drain),
    .reg_i   (wb.mem_reg),
    .data_i  (wb.mem_data),
    .valid_o (mem_v),
    .reg_o   (mem_reg_q),
    .data_o  (mem_data_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Age tracking: an entry that survives the edge is older than anything
  // captured on it; two fresh captures on one edge put the load first.
  // Both slots surviving is impossible because one is always granted.
  always_comb begin
    state_d = state_q;
    alu_v_d = alu_take || alu_keep;
    mem_v_d = mem_take || mem_keep;
    unique case ({alu_v_d, mem_v_d})
      2'b00: state_d = ST_EMPTY;
      2'b10: state_d = ST_ALU_ONLY;
      2'b01: state_d = ST_MEM_ONLY;
      2'b11: state_d = alu_keep ? ST_BOTH_ALU_OLD : ST_BOTH_MEM_OLD;
    endcase
  end

  always_comb begin
    wb.write_enable = 1'b0;
    wb.write_reg    = '0;
    wb.write_data   = '0;
    case (grant)
      GNT_ALU: begin
        wb.write_enable = 1'b1;
        wb.write_reg    = alu_reg_q;
        wb.write_data   = alu_data_q;
      end
      GNT_MEM: begin
        wb.write_enable = 1'b1;
        wb.write_reg    = mem_reg_q;
        wb.write_data   = mem_data_q;
      end
      default: ;
    endcase
  end

  // Pending is computed from the post-edge slot contents and registered
  // alongside them, so it always matches what the slots hold.
  always_comb begin
    alu_reg_d = alu_take ? wb.alu_reg : alu_reg_q;
    mem_reg_d = mem_take ? wb.mem_reg : mem_reg_q;
    pending_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      pending_d[r] = (alu_v_d && (alu_reg_d == ADDR_W'(r))) ||
                     (mem_v_d && (mem_reg_d == ADDR_W'(r)));
    end
  end

  assign wb.pending = pending_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter
//   Directed bench for reg_wb_arbiter with a small reg_file model fed by the
//   arbiter's write port.
module tb_reg_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.DATA_W(8), .ADDR_W(3), .NREGS(8)) wb ();

  reg_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .NREGS(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb)
  );

  logic [7:0] rf [8] = '{default: 8'h00};
  always @(posedge clk) if (wb.write_enable) rf[wb.write_reg] <= wb.write_data;

  int n_vec    = 0;
  int n_miscmp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic a_acc, m_acc, got;
    int   waited;
    logic [7:0] exp_d;

    wb.alu_req = 1'b0; wb.alu_reg = '0; wb.alu_data = '0;
    wb.mem_req = 1'b0; wb.mem_reg = '0; wb.mem_data = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    check("rst_we",      32'(wb.write_enable), 32'd0);
    check("rst_pending", 32'(wb.pending),      32'h00);
    check("rst_alu_rdy", 32'(wb.alu_ready),    32'd1);
    check("rst_mem_rdy", 32'(wb.mem_ready),    32'd1);

    // single ALU write r2=95
    wb.alu_req = 1'b1; wb.alu_reg = 3'd2; wb.alu_data = 8'd95;
    check("t2_alu_rdy", 32'(wb.alu_ready), 32'd1);
    step();
    wb.alu_req = 1'b0;
    check("t2_we",      32'(wb.write_enable), 32'd1);
    check("t2_wreg",    32'(wb.write_reg),    32'd2);
    check("t2_wdata",   32'(wb.write_data),   32'd95);
    check("t2_pending", 32'(wb.pending),      32'h04);
    step();
    check("t2_rf2",     32'(rf[2]),           32'd95);
    check("t2_we_off",  32'(wb.write_enable), 32'd0);
    check("t2_pend_off",32'(wb.pending),      32'h00);

    // reset while the ALU slot holds r2=77
    wb.alu_req = 1'b1; wb.alu_reg = 3'd2; wb.alu_data = 8'd77;
    step();
    wb.alu_req = 1'b0;
    check("t1_held_pending", 32'(wb.pending), 32'h04);
    rst = 1'b1;
    #1;
    check("t1_we",      32'(wb.write_enable), 32'd0);
    check("t1_wreg",    32'(wb.write_reg),    32'd0);
    check("t1_wdata",   32'(wb.write_data),   32'd0);
    check("t1_pending", 32'(wb.pending),      32'h00);
    check("t1_alu_rdy", 32'(wb.alu_ready),    32'd1);
    check("t1_mem_rdy", 32'(wb.mem_ready),    32'd1);
    step();
    rst = 1'b0;
    step();
    check("t1_rf2_kept", 32'(rf[2]), 32'd95);

    // collision: ALU r1=28 and MEM r4=6 on the same edge
    wb.alu_req = 1'b1; wb.alu_reg = 3'd1; wb.alu_data = 8'd28;
    wb.mem_req = 1'b1; wb.mem_reg = 3'd4; wb.mem_data = 8'd6;
    step();
    wb.alu_req = 1'b0; wb.mem_req = 1'b0;
    check("t3_pending0", 32'(wb.pending),    32'h12);
    check("t3_wreg0",    32'(wb.write_reg),  32'd4);
    check("t3_wdata0",   32'(wb.write_data), 32'd6);
    step();
    check("t3_rf4",      32'(rf[4]),         32'd6);
    check("t3_pending1", 32'(wb.pending),    32'h02);
    check("t3_wreg1",    32'(wb.write_reg),  32'd1);
    check("t3_wdata1",   32'(wb.write_data), 32'd28);
    step();
    check("t3_rf1",      32'(rf[1]),         32'd28);
    check("t3_pending2", 32'(wb.pending),    32'h00);

    // same register: MEM r4=3, then ALU r4=15 one edge later
    wb.mem_req = 1'b1; wb.mem_reg = 3'd4; wb.mem_data = 8'd3;
    step();
    wb.mem_req = 1'b0;
    wb.alu_req = 1'b1; wb.alu_reg = 3'd4; wb.alu_data = 8'd15;
    check("t4_wdata0",  32'(wb.write_data), 32'd3);
    check("t4_alu_rdy", 32'(wb.alu_ready),  32'd1);
    step();
    wb.alu_req = 1'b0;
    check("t4_rf4_a",   32'(rf[4]),         32'd3);
    check("t4_wdata1",  32'(wb.write_data), 32'd15);
    check("t4_pending", 32'(wb.pending),    32'h10);
    step();
    check("t4_rf4_b",   32'(rf[4]),         32'd15);
    check("t4_pend_off",32'(wb.pending),    32'h00);

    // streaming: both sources request for 6 edges; writes alternate MEM, ALU
    wb.alu_req = 1'b1; wb.alu_reg = 3'd5; wb.alu_data = 8'h50;
    wb.mem_req = 1'b1; wb.mem_reg = 3'd6; wb.mem_data = 8'h60;
    for (int k = 1; k <= 6; k++) begin
      a_acc = wb.alu_req && wb.alu_ready;
      m_acc = wb.mem_req && wb.mem_ready;
      step();
      if (a_acc) wb.alu_data = wb.alu_data + 8'd1;
      if (m_acc) wb.mem_data = wb.mem_data + 8'd1;
      if (k == 6) begin
        wb.alu_req = 1'b0; wb.mem_req = 1'b0;
      end
      check($sformatf("t5_we_%0d", k), 32'(wb.write_enable), 32'd1);
      if (k % 2 == 1) begin
        exp_d = 8'h60 + 8'((k - 1) / 2);
        check($sformatf("t5_wreg_%0d", k),  32'(wb.write_reg),  32'd6);
        check($sformatf("t5_rdy_%0d", k),   32'(wb.mem_ready),  32'd1);
        check($sformatf("t5_block_%0d", k), 32'(wb.alu_ready),  32'd0);
      end else begin
        exp_d = 8'h50 + 8'(k / 2 - 1);
        check($sformatf("t5_wreg_%0d", k),  32'(wb.write_reg),  32'd5);
        check($sformatf("t5_rdy_%0d", k),   32'(wb.alu_ready),  32'd1);
        check($sformatf("t5_block_%0d", k), 32'(wb.mem_ready),  32'd0);
      end
      check($sformatf("t5_wdata_%0d", k), 32'(wb.write_data), 32'(exp_d));
    end
    step();
    check("t5_tail_wreg",  32'(wb.write_reg),  32'd6);
    check("t5_tail_wdata", 32'(wb.write_data), 32'h63);
    step();
    check("t5_idle", 32'(wb.write_enable), 32'd0);
    check("t5_rf5",  32'(rf[5]),           32'h52);
    check("t5_rf6",  32'(rf[6]),           32'h63);

    // backpressure: MEM refills every cycle, held ALU r7=50 must still drain
    wb.mem_req = 1'b1; wb.mem_reg = 3'd3; wb.mem_data = 8'd1;
    step();
    wb.alu_req = 1'b1; wb.alu_reg = 3'd7; wb.alu_data = 8'd50;
    wb.mem_data = 8'd2;
    step();
    wb.alu_req = 1'b0;
    wb.mem_data = 8'd3;
    check("t6_pending", 32'(wb.pending), 32'h88);
    got = 1'b0;
    waited = 0;
    for (int c = 0; c < 4; c++) begin
      if (wb.write_enable && wb.write_reg == 3'd7) begin
        got = 1'b1;
        break;
      end
      m_acc = wb.mem_req && wb.mem_ready;
      step();
      waited++;
      if (m_acc) wb.mem_data = wb.mem_data + 8'd1;
    end
    check("t6_alu_granted", 32'(got && waited <= 2), 32'd1);
    check("t6_wdata",       32'(wb.write_data),      32'd50);
    wb.mem_req = 1'b0;
    step();
    check("t6_rf7", 32'(rf[7]), 32'd50);
    step();
    check("t6_idle", 32'(wb.write_enable), 32'd0);
    check("t6_rf3",  32'(rf[3]),           32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
